// File: rtl/instr_fetch.sv
// Instruction fetch/sequencing stage: loadable program memory, PC stepping, one registered
// instruction (or NOP) per cycle. Optional macro IFETCH_LOOP_EN makes the program repeat forever.
module instr_fetch #(
  parameter int                     INSTR_WIDTH = 20,
  parameter int                     PC_BITS     = 5,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_en,
  input  logic [PC_BITS-1:0]     load_addr,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic [PC_BITS:0]       prog_len,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   stall,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [PC_BITS-1:0]     pc,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int DEPTH = 2 ** PC_BITS;

  state_t                 state_q;
  logic [PC_BITS-1:0]     pc_q;
  logic [PC_BITS:0]       len_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [INSTR_WIDTH-1:0] mem_q [DEPTH];

  logic                   last_d;
  logic [PC_BITS-1:0]     pc_d;

  // last_d flags the issue of the final word; pc_d naturally wraps at 2^PC_BITS
  assign last_d = ({1'b0, pc_q} == (len_q - {{PC_BITS{1'b0}}, 1'b1}));
  assign pc_d   = pc_q + {{(PC_BITS-1){1'b0}}, 1'b1};

  // Program memory is deliberately left out of reset; writes are locked out while running
  always_ff @(posedge clk) begin
    if (load_en && (state_q != RUN)) begin
      mem_q[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      instr_q <= NOP_INSTR;
    end else begin
      case (state_q)
        RUN: begin
          if (abort) begin
            state_q <= IDLE;
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
          end else if (stall) begin
            instr_q <= NOP_INSTR;
          end else begin
            instr_q <= mem_q[pc_q];
`ifdef IFETCH_LOOP_EN
            pc_q    <= last_d ? '0 : pc_d;
`else
            pc_q    <= pc_d;
            if (last_d) begin
              state_q <= DONE;
            end
`endif
          end
        end
        default: begin
          instr_q <= NOP_INSTR;
          if (start) begin
            len_q   <= prog_len;
            pc_q    <= '0;
            state_q <= (prog_len != '0) ? RUN : DONE;
          end
        end
      endcase
    end
  end

  assign instruction = instr_q;
  assign pc          = pc_q;
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed stimulus pushes per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en;
  logic [4:0]  load_addr;
  logic [19:0] load_data;
  logic [5:0]  prog_len;
  logic        start, abort, stall;
  logic [19:0] instruction;
  logic [4:0]  pc;
  logic        busy, done;

  instr_fetch dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .prog_len(prog_len), .start(start), .abort(abort), .stall(stall),
    .instruction(instruction), .pc(pc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [19:0] ins;
    logic [4:0]  pc;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, req);
    end
  endtask

  // Monitor: compares the expectation tagged for the current cycle
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.cyc != cyc) begin
        chk("sb_missed", cyc, e.cyc);
      end else begin
        chk("instruction", {12'd0, instruction}, {12'd0, e.ins});
        chk("pc", {27'd0, pc}, {27'd0, e.pc});
        chk("busy", {31'd0, busy}, {31'd0, e.busy});
        chk("done", {31'd0, done}, {31'd0, e.done});
      end
    end
  end

  // Entered right at a rising edge; drives inputs, queues outputs expected after the next edge
  task automatic step(input logic ld, input logic [4:0] la, input logic [19:0] ldat,
                      input logic [5:0] pl, input logic st, input logic ab, input logic sl,
                      input logic [19:0] ei, input logic [4:0] epc, input logic eb, input logic ed);
    exp_t x;
    #1;
    load_en = ld; load_addr = la; load_data = ldat;
    prog_len = pl; start = st; abort = ab; stall = sl;
    x.cyc = cyc + 1; x.ins = ei; x.pc = epc; x.busy = eb; x.done = ed;
    q.push_back(x);
    @(posedge clk);
  endtask

  task automatic idle(input logic [19:0] ei, input logic [4:0] epc, input logic eb, input logic ed);
    step(1'b0, 5'd0, 20'd0, 6'd0, 1'b0, 1'b0, 1'b0, ei, epc, eb, ed);
  endtask

  task automatic go(input logic [5:0] pl, input logic [19:0] ei, input logic [4:0] epc,
                    input logic eb, input logic ed);
    step(1'b0, 5'd0, 20'd0, pl, 1'b1, 1'b0, 1'b0, ei, epc, eb, ed);
  endtask

  task automatic run4;
    go(6'd4, 20'h0, 5'd0, 1'b1, 1'b0);
    idle(20'h11111, 5'd1, 1'b1, 1'b0);
    idle(20'h22222, 5'd2, 1'b1, 1'b0);
    idle(20'h33333, 5'd3, 1'b1, 1'b0);
    idle(20'h44444, 5'd4, 1'b0, 1'b1);
    idle(20'h0,     5'd4, 1'b0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    prog_len = '0; start = 1'b0; abort = 1'b0; stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_instruction", {12'd0, instruction}, 32'h0);
    chk("rst_pc", {27'd0, pc}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b1;
    @(posedge clk);

    // Zero-length run goes straight to DONE
    go(6'd0, 20'h0, 5'd0, 1'b0, 1'b1);
    idle(20'h0, 5'd0, 1'b0, 1'b1);

    step(1'b1, 5'd0, 20'h11111, 6'd0, 1'b0, 1'b0, 1'b0, 20'h0, 5'd0, 1'b0, 1'b1);
    step(1'b1, 5'd1, 20'h22222, 6'd0, 1'b0, 1'b0, 1'b0, 20'h0, 5'd0, 1'b0, 1'b1);
    step(1'b1, 5'd2, 20'h33333, 6'd0, 1'b0, 1'b0, 1'b0, 20'h0, 5'd0, 1'b0, 1'b1);
    step(1'b1, 5'd3, 20'h44444, 6'd0, 1'b0, 1'b0, 1'b0, 20'h0, 5'd0, 1'b0, 1'b1);

    run4();
    step(1'b0, 5'd0, 20'd0, 6'd0, 1'b0, 1'b1, 1'b0, 20'h0, 5'd4, 1'b0, 1'b1);

    // One stall cycle after the second issue
    go(6'd4, 20'h0, 5'd0, 1'b1, 1'b0);
    idle(20'h11111, 5'd1, 1'b1, 1'b0);
    idle(20'h22222, 5'd2, 1'b1, 1'b0);
    step(1'b0, 5'd0, 20'd0, 6'd0, 1'b0, 1'b0, 1'b1, 20'h0, 5'd2, 1'b1, 1'b0);
    idle(20'h33333, 5'd3, 1'b1, 1'b0);
    idle(20'h44444, 5'd4, 1'b0, 1'b1);
    idle(20'h0,     5'd4, 1'b0, 1'b1);

    // Load during RUN is ignored; abort at pc=2 overrides stall and start
    go(6'd4, 20'h0, 5'd0, 1'b1, 1'b0);
    idle(20'h11111, 5'd1, 1'b1, 1'b0);
    step(1'b1, 5'd0, 20'hFFFFF, 6'd0, 1'b0, 1'b0, 1'b0, 20'h22222, 5'd2, 1'b1, 1'b0);
    step(1'b0, 5'd0, 20'd0, 6'd4, 1'b1, 1'b1, 1'b1, 20'h0, 5'd0, 1'b0, 1'b0);
    idle(20'h0, 5'd0, 1'b0, 1'b0);

    // Rerun, then async reset between edges
    go(6'd4, 20'h0, 5'd0, 1'b1, 1'b0);
    idle(20'h11111, 5'd1, 1'b1, 1'b0);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("arst_instruction", {12'd0, instruction}, 32'h0);
    chk("arst_pc", {27'd0, pc}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    run4();

    // Full-depth program: 32 words, pc wraps to 0
    for (int i = 0; i < 32; i++)
      step(1'b1, 5'(i), 20'h50000 + 20'(i), 6'd0, 1'b0, 1'b0, 1'b0, 20'h0, 5'd4, 1'b0, 1'b1);
    go(6'd32, 20'h0, 5'd0, 1'b1, 1'b0);
    for (int i = 0; i < 32; i++)
      idle(20'h50000 + 20'(i), 5'(i + 1), (i != 31), (i == 31));
    idle(20'h0, 5'd0, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    chk("sb_drained", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch and sequencing stage that drives the 20-bit `instruction` input of the CPU. It holds a loadable program memory and steps a program counter through it. It issues one registered instruction per cycle, or a NOP while idle, stalled or finished. It is controlled by start, abort and stall inputs.

## Interface
- `INSTR_WIDTH`, 20, instruction word width.
- `PC_BITS`, 5, program-counter width; program memory depth is 2^PC_BITS words.
- `NOP_INSTR`, 20'h00000, word driven on `instruction` when no instruction is issued.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low (`rst`=0 resets).
- `load_en`  in  1  program-memory write strobe.
- `load_addr`  in  PC_BITS  write address.
- `load_data`  in  INSTR_WIDTH  write data.
- `prog_len`  in  PC_BITS+1  number of instructions to issue, 0..2^PC_BITS; sampled when the run starts.
- `start`  in  1  begin a run from address 0.
- `abort`  in  1  terminate a run immediately.
- `stall`  in  1  hold the PC and issue a NOP this cycle.
- `instruction`  out  INSTR_WIDTH  registered instruction to the CPU.
- `pc`  out  PC_BITS  address of the next instruction to issue.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.

## Operation
- States: IDLE, RUN, DONE.
- Reset state, asynchronous: state=IDLE, `pc`=0, `instruction`=NOP_INSTR, `busy`=0, `done`=0, latched length=0.
- Program memory is not cleared by reset.
- IDLE/DONE, `start`=1:
  - latch `prog_len`, set `pc`=0.
  - go to RUN if the latched length is non-zero; otherwise go to DONE.
  - `instruction`=NOP_INSTR on this edge.
- RUN, `stall`=0: `instruction`<=mem[`pc`], `pc`<=`pc`+1 (modulo 2^PC_BITS).
  - If `pc`==length-1, go to DONE. With `prog_len`=2^PC_BITS, the final `pc` wraps to 0.
- RUN, `stall`=1: `pc` held, `instruction`<=NOP_INSTR. A stalled instruction is never issued twice.
- RUN, `abort`=1: go to IDLE, `instruction`<=NOP_INSTR, `pc`<=0.
  - `abort` overrides `stall` and `start`.
  - `abort` has no effect outside RUN.
- DONE: `instruction`<=NOP_INSTR, `done`=1. Stays in DONE until `start`.
- `start` during RUN is ignored.
- `load_en` is honoured only in IDLE/DONE: mem[`load_addr`]<=`load_data` on the edge.
  - `load_en` in RUN is ignored, so the program cannot be modified mid-run.
- Load and `start` in the same IDLE cycle: the write completes, then the run begins. The run's first read at address 0 occurs one edge later and sees the new word.

## Timing
- `instruction` is a flop output; there is no combinational path from any input to `instruction`.
- `start` sampled at edge k gives:
  - mem[0] at edge k+1;
  - mem[n] at edge k+1+n, with no stalls;
  - each stall cycle delays all later issues by one cycle.
- The last instruction issues at edge k+L (L = latched length). DONE is entered on that same edge, so `done`=1 and `busy`=0 from edge k+L. `instruction`=NOP_INSTR from edge k+L+1.
- `busy`/`done` are decoded from the state register and are glitch-free.
- Asynchronous reset asserted mid-run immediately forces the reset values. The first edge after release behaves as IDLE.

## Configuration
- `IFETCH_LOOP_EN`:
  - Defined: in RUN, when `pc`==length-1 issues, `pc`<=0 and the state stays RUN, so the program repeats until `abort` or reset. DONE is unreachable except through `prog_len`=0.
  - Undefined: terminate in DONE as above.

## Test plan
- Load mem[0..3]=20'h11111, 20'h22222, 20'h33333, 20'h44444; `prog_len`=4; pulse `start` at edge k -> `instruction` shows the four words at edges k+1..k+4; `done`=1 from edge k+4; NOP_INSTR at edge k+5.
- Same program, `stall`=1 for the one cycle after the second issue -> sequence 11111, 22222, NOP, 33333, 44444, with no word duplicated.
- `abort` while `pc`=2 -> `instruction`=NOP_INSTR, `pc`=0, `busy`=0 after the next edge; a later `start` reruns from 20'h11111.
- `rst`=0 asserted between edges mid-run -> outputs at reset values immediately; memory contents intact on the next run.
- `prog_len`=0 with `start` -> DONE on the next edge with no instruction issued. `prog_len`=32 -> all 32 words issued, and `pc` wraps to 0.
- With `IFETCH_LOOP_EN`: `prog_len`=2 -> 11111, 22222, 11111, 22222 continues until `abort`. In RUN, `load_en` writing 20'hFFFFF to address 0 -> memory unchanged.
